// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM front-end.
package sp_ram_ctrl_pkg;

    localparam int       DATA_W  = 32;
    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RMW_WAIT = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_RSP      = 3'd5
    } state_t;

endpackage

// File: rtl/sp_ram_be_merge.sv
// Combinational 32-bit byte merge: each byte comes from i_new where i_be is set, else from i_old.
module sp_ram_be_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [3:0]  i_be,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
        end
    end

endmodule

// File: rtl/sp_ram_ctrl.sv
// Load/store front-end for a single-port no-change block RAM, with read-modify-write for partial stores.
// Optional upper-address error checking is enabled by defining SP_RAM_CTRL_ADDR_CHK_EN.
module sp_ram_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int RAM_LATENCY = 2
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_regce,
    output logic              ram_rst,
    input  logic [31:0]       ram_dout
);

    state_t              r_state, w_nxt_state;
    logic                r_req_ready, w_nxt_req_ready;
    logic                r_rsp_valid, w_nxt_rsp_valid;
    logic [31:0]         r_rsp_rdata, w_nxt_rsp_rdata;
    logic                r_rsp_err, w_nxt_rsp_err;
    logic                r_ram_en, w_nxt_ram_en;
    logic                r_ram_we, w_nxt_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr, w_nxt_ram_addr;
    logic [31:0]         r_ram_din, w_nxt_ram_din;
    logic [1:0]          r_cnt, w_nxt_cnt;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                w_accept;
    logic                w_addr_err;
    logic [31:0]         w_merged;
    logic                w_unused;

`ifdef SP_RAM_CTRL_ADDR_CHK_EN
    assign w_addr_err = |req_addr[DATA_W-1:ADDR_W+2];
    assign w_unused   = ^req_addr[1:0];
`else
    assign w_addr_err = 1'b0;
    assign w_unused   = ^{req_addr[1:0], req_addr[DATA_W-1:ADDR_W+2]};
`endif

    assign w_accept = req_valid && r_req_ready;

    sp_ram_be_merge u_merge (
        .i_old    (ram_dout),
        .i_new    (r_wdata),
        .i_be     (r_be),
        .o_merged (w_merged)
    );

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_rsp_valid = r_rsp_valid;
        w_nxt_rsp_rdata = r_rsp_rdata;
        w_nxt_rsp_err   = r_rsp_err;
        w_nxt_ram_en    = 1'b0;
        w_nxt_ram_we    = 1'b0;
        w_nxt_ram_addr  = r_ram_addr;
        w_nxt_ram_din   = r_ram_din;
        w_nxt_cnt       = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_addr_err) begin
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_rdata = '0;
                        w_nxt_rsp_err   = 1'b1;
                        w_nxt_state     = ST_RSP;
                    end else if (req_we && req_be == BE_NONE) begin
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_rdata = '0;
                        w_nxt_rsp_err   = 1'b0;
                        w_nxt_state     = ST_RSP;
                    end else if (req_we && req_be == BE_FULL) begin
                        w_nxt_ram_en   = 1'b1;
                        w_nxt_ram_we   = 1'b1;
                        w_nxt_ram_addr = req_addr[ADDR_W+1:2];
                        w_nxt_ram_din  = req_wdata;
                        w_nxt_state    = ST_WR_ISSUE;
                    end else begin
                        // loads and partial stores both start with a read
                        w_nxt_ram_en   = 1'b1;
                        w_nxt_ram_addr = req_addr[ADDR_W+1:2];
                        w_nxt_state    = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                w_nxt_cnt   = 2'(RAM_LATENCY - 1);
                w_nxt_state = r_we ? ST_RMW_WAIT : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_rsp_rdata = ram_dout;
                    w_nxt_rsp_err   = 1'b0;
                    w_nxt_state     = ST_RSP;
                end else begin
                    w_nxt_cnt = r_cnt - 2'd1;
                end
            end
            ST_RMW_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_nxt_ram_en  = 1'b1;
                    w_nxt_ram_we  = 1'b1;
                    w_nxt_ram_din = w_merged;
                    w_nxt_state   = ST_WR_ISSUE;
                end else begin
                    w_nxt_cnt = r_cnt - 2'd1;
                end
            end
            ST_WR_ISSUE: begin
                w_nxt_rsp_valid = 1'b1;
                w_nxt_rsp_rdata = '0;
                w_nxt_rsp_err   = 1'b0;
                w_nxt_state     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_nxt_rsp_valid = 1'b0;
                    w_nxt_state     = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        w_nxt_req_ready = (w_nxt_state == ST_IDLE) && !w_nxt_rsp_valid;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_req_ready <= w_nxt_req_ready;
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_rdata <= w_nxt_rsp_rdata;
            r_rsp_err   <= w_nxt_rsp_err;
            r_ram_en    <= w_nxt_ram_en;
            r_ram_we    <= w_nxt_ram_we;
            r_ram_addr  <= w_nxt_ram_addr;
            r_ram_din   <= w_nxt_ram_din;
            r_cnt       <= w_nxt_cnt;
            if (w_accept) begin
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_regce = 1'b1;
    assign ram_rst   = rsta;

endmodule

// File: doc/sp_ram_ctrl.md
Name: sp_ram_ctrl

Overview:
- Request/response front-end that sits directly upstream of the single-port no-change block RAM (SP_RAM) and drives its port A.
- Converts a core-side valid/ready load/store bus (32-bit data, byte enables) into RAM enable/write/address cycles.
- Tracks the RAM's 1- or 2-cycle read latency.
- Implements partial (byte/half-word) stores as read-modify-write, because the RAM has no byte enables.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM depth is 2**ADDR_W 32-bit words.
- RAM_LATENCY, 2, RAM read latency in cycles: 1 = LOW_LATENCY RAM, 2 = HIGH_PERFORMANCE RAM. Must match the RAM instance.

Ports:
- clka  in  1  clock
- rsta  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; ignored for loads
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_rdata  out  32  load data; 0 for stores
- rsp_err  out  1  address error (see Optional Feature)
- ram_en  out  1  RAM ena
- ram_we  out  1  RAM wea
- ram_addr  out  ADDR_W  RAM addra
- ram_din  out  32  RAM dina
- ram_regce  out  1  RAM regcea; constant 1
- ram_rst  out  1  RAM rsta; equals rsta
- ram_dout  in  32  RAM douta

Behaviour:
- Clock and reset: clka, rsta; reset is synchronous and active-high. Single outstanding transaction.
- req_ready=1 only in IDLE with rsp_valid=0.
- All RAM outputs are registered; ram_en is 1 for exactly one cycle per RAM access.
- Reset values: state=IDLE, req_ready=0 during reset (1 the cycle after), rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- States: IDLE, RD_ISSUE, RD_WAIT, RMW_WAIT, WR_ISSUE, RSP.
- Load accepted in cycle T:
  - RD_ISSUE in T+1: en=1, we=0.
  - RD_WAIT counts RAM_LATENCY cycles; ram_dout is captured in cycle T+1+RAM_LATENCY.
  - rsp_valid=1 from T+2+RAM_LATENCY.
- Full store (be=4'hF): WR_ISSUE in T+1 (en=1, we=1, din=wdata); rsp_valid from T+2.
- Partial store (be ∉ {0, F}):
  - Read as for a load, entering RMW_WAIT.
  - Merge per byte: byte i = be[i] ? wdata byte i : ram_dout byte i.
  - WR_ISSUE in T+2+RAM_LATENCY; rsp_valid from T+3+RAM_LATENCY.
- Store with be=0: no RAM access; rsp_valid from T+1.
- RSP state: rsp_valid and rsp_rdata are held stable until rsp_ready. The cycle rsp_valid&&rsp_ready is seen, the block returns to IDLE and req_ready=1 the next cycle. No back-to-back issue.
- Address mapping: ram_addr = req_addr[ADDR_W+1:2]. Upper bits are handled per the Optional Feature.
- Request fields are latched at accept; later changes on req_* are ignored.
- Reset mid-operation: returns to IDLE immediately and drops any pending response. A write already issued to the RAM stays written. An uncommitted RMW does not write.
- The RAM is no-change mode: a write does not update ram_dout. The block never uses ram_dout after a write.

Optional Feature:
- Macro SP_RAM_CTRL_ADDR_CHK_EN.
- Defined:
  - req_addr[31:ADDR_W+2] != 0 → no RAM access.
  - Response in T+1 with rsp_err=1, rsp_rdata=0.
  - rsp_err=0 on all valid accesses.
- Undefined: upper address bits are ignored (addresses alias modulo 4*2**ADDR_W); rsp_err is tied to 0.

Decomposition:
- Package sp_ram_ctrl_pkg:
  - state enum
  - BE_FULL=4'hF
  - BE_NONE=4'h0
  - DATA_W=32
- One sub-module sp_ram_be_merge: combinational 32-bit byte merge (old, new, be → merged). Reused by other memory clients.

Test Plan:
- RAM_LATENCY=2: store 0xDEADBEEF at addr 0x10, be=F, then load 0x10 → ram_en/we pulse at T+1; store rsp at T+2; load rsp_rdata=0xDEADBEEF at T+4.
- Byte merge: word 0x11223344 at 0x20; store wdata=0x0000AA00, be=4'b0010 → exactly one read then one write; reload returns 0x1122AA44.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load → rsp_valid/rsp_rdata stay stable, req_ready=0; release → req_ready=1 the next cycle.
- be=0 store to 0x30 containing 0x55AA55AA → ram_en never asserted; rsp at T+1; reload reads 0x55AA55AA.
- Reset during RMW_WAIT of a be=4'b0001 store → ram_we never asserted; outputs at reset values; memory unchanged.
- With SP_RAM_CTRL_ADDR_CHK_EN, ADDR_W=10, load 0x00001000 → rsp_err=1, rsp_rdata=0, no ram_en. Without the macro, the same load aliases to word 0.
